// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a single-ported RAM between an instruction-fetch requester and
//   a data requester. Data requests always win over simultaneous instruction
//   requests. Each completed access is followed by a one-cycle DONE bubble so
//   the requester can drop its request before the next arbitration.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               instruction read request / word address
//   iload, ihit               instruction read data / completion strobe
//   dREN, dWEN, daddr, dstore data read/write request, address, write value
//   dload, dhit               data read value / completion strobe
//   ramREN, ramWEN            RAM enables
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (FREE,BUSY,ACCESS,ERROR)
//   memerr                    sticky error (RAM ERROR or wait timeout)
//   icount, dcount, stallcount statistics counters
//
// Build option
//   MEM_ARB_STATS_EN : when defined, icount/dcount/stallcount are live
//   wrapping counters; otherwise the ports are tied to 0.
// ---------------------------------------------------------------------------
module mem_arbiter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcount
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic d_req;
  logic active;
  logic access_ok;

  assign d_req = dREN | dWEN;

  // An access state is only "live" while its requester still holds the
  // request; a dropped request aborts the access without a hit.
  assign active    = ((state == DACC) && d_req) || ((state == IACC) && iREN);
  assign access_ok = active && (ramstate == RAM_ACCESS);

  // RAM-side and requester-side outputs are decoded from the state so that
  // the hit can follow ramstate in the same cycle. Async reset forces IDLE,
  // which makes every output 0 immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    case (state)
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;   // read+write together is a write
        if (access_ok) begin
          dhit  = 1'b1;
          dload = ramload;
        end
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (access_ok) begin
          ihit  = 1'b1;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      memerr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Clearing here covers every entry into DACC/IACC.
          wait_cnt <= '0;
          if (d_req)     state <= DACC;
          else if (iREN) state <= IACC;
        end
        DACC, IACC: begin
          if (!active) begin
            state <= IDLE;
          end else if (ramstate == RAM_ERROR) begin
            memerr <= 1'b1;
            state  <= IDLE;
          end else if (ramstate == RAM_ACCESS) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            // This wait cycle brings the counter to 255: give up.
            if (wait_cnt == 8'd254) begin
              memerr <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic        stall;
  logic [31:0] icount_reg;
  logic [31:0] dcount_reg;
  logic [31:0] stallcount_reg;

  assign stall = ((state == DACC) || (state == IACC)) && (ramstate != RAM_ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_reg     <= '0;
      dcount_reg     <= '0;
      stallcount_reg <= '0;
    end else begin
      if (ihit)  icount_reg     <= icount_reg + 32'd1;
      if (dhit)  dcount_reg     <= dcount_reg + 32'd1;
      if (stall) stallcount_reg <= stallcount_reg + 32'd1;
    end
  end

  assign icount     = icount_reg;
  assign dcount     = dcount_reg;
  assign stallcount = stallcount_reg;
`else
  assign icount     = '0;
  assign dcount     = '0;
  assign stallcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench plays both requesters and
//   a RAM slave whose BUSY latency is chosen per access. Expected data comes
//   from a reference memory updated from the requesters' point of view
//   (writes land, reads return the latest write), and expected counters from
//   per-transaction totals.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount, stallcount;
  logic        ihit, dhit, ramREN, ramWEN, memerr;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr),
    .icount(icount), .dcount(dcount), .stallcount(stallcount)
  );

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  // RAM slave contents and the requesters' view of memory.
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int exp_i, exp_d, exp_stall;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef MEM_ARB_STATS_EN
    check({tag, "_icount"}, icount, exp_i);
    check({tag, "_dcount"}, dcount, exp_d);
    check({tag, "_stallcount"}, stallcount, exp_stall);
`else
    check({tag, "_icount"}, icount, 32'h0);
    check({tag, "_dcount"}, dcount, 32'h0);
    check({tag, "_stallcount"}, stallcount, 32'h0);
`endif
  endtask

  // Leaves the bench in the drive phase (just after a rising edge) in IDLE.
  task automatic do_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    #1;
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_hits", {ihit, dhit}, 0);
    check("rst_memerr", memerr, 0);
    check("rst_ramaddr", ramaddr, 0);
    exp_i = 0; exp_d = 0; exp_stall = 0;
    check_counters("rst");
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  // Run one instruction request and/or one data request (dmode: 0 none,
  // 1 read, 2 write, 3 read+write) to completion. The slave answers each
  // access with bi/bd BUSY cycles then ACCESS.
  task automatic run_req(input bit use_i, input logic [31:0] ia,
                         input int dmode, input logic [31:0] da, input logic [31:0] ds,
                         input int bi, input int bd,
                         output logic [31:0] iout, output logic [31:0] dout);
    bit pi, pd, drop_i, drop_d, last_hit, en;
    int seen, planned, cyc;
    pi = use_i; pd = (dmode != 0);
    iREN = pi; iaddr = ia;
    dREN = (dmode == 1) || (dmode == 3); dWEN = (dmode >= 2);
    daddr = da; dstore = ds;
    iout = '0; dout = '0;
    seen = 0; cyc = 0; last_hit = 0;
    txn_no++;
    $display("txn %0d: i=%0b iaddr=%08h dmode=%0d daddr=%08h dstore=%08h busy_i=%0d busy_d=%0d",
             txn_no, use_i, ia, dmode, da, ds, bi, bd);
    while ((pi || pd) && cyc < 500) begin
      drop_i = 0; drop_d = 0;
      #1;
      en = ramREN | ramWEN;
      planned = pd ? bd : bi;
      if (en) begin
        ramstate = (seen < planned) ? BUSY : ACCESS;
        ramload  = ram_rd(ramaddr);
        seen++;
      end else begin
        ramstate = FREE;
        ramload  = $urandom;
        seen     = 0;
      end
      #1;
      check("both_hits", ihit & dhit, 0);
      if (last_hit) check("bubble_en", en, 0);
      last_hit = 0;
      if (en && seen == 1) begin
        if (pd) begin
          check("d_ramaddr", ramaddr, da);
          check("d_ramWEN", ramWEN, (dmode >= 2));
          check("d_ramREN", ramREN, (dmode == 1));
          check("d_ramstore", ramstore, ds);
        end else begin
          check("i_ramaddr", ramaddr, ia);
          check("i_ramREN", ramREN, 1);
          check("i_ramWEN", ramWEN, 0);
        end
      end
      if (ihit || dhit) begin
        if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr] = ramstore;
        if (pd) begin
          check("d_first", {ihit, dhit}, 2'b01);
          check("d_latency", seen - 1, bd);
          if (dmode == 1) check("dload", dload, ref_rd(da));
          else            ref_mem[da] = ds;
          dout = dload; exp_d++; exp_stall += bd; drop_d = 1;
        end else begin
          check("i_hit", {ihit, dhit}, 2'b10);
          check("i_latency", seen - 1, bi);
          check("iload", iload, ref_rd(ia));
          iout = iload; exp_i++; exp_stall += bi; drop_i = 1;
        end
        last_hit = 1;
      end
      @(posedge CLK); #1;
      if (drop_d) begin pd = 0; dREN = 0; dWEN = 0; end
      if (drop_i) begin pi = 0; iREN = 0; end
      cyc++;
    end
    if (cyc >= 500) check("txn_timeout", cyc, 0);
    // DONE bubble after the last hit, then back to IDLE.
    ramstate = FREE;
    #1;
    check("done_bubble", {ramREN, ramWEN, ihit, dhit}, 4'b0);
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit          use_i;
    int          dmode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;
    bit          do_pre;
    logic [31:0] preload;
    logic [31:0] exp_load;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [31:0] io, dv;

    vecs[0] = '{1'b1, 0, 32'h40,  32'h0,        2, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1, 32'h100, 32'h0,        0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 2, 32'h200, 32'h12345678, 3, 1'b0, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 3, 32'h300, 32'hA5A5A5A5, 1, 1'b0, 32'h0,        32'hA5A5A5A5};
    vecs[4] = '{1'b1, 0, 32'h200, 32'h0,        1, 1'b0, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 1, 32'h300, 32'h0,        0, 1'b0, 32'h0,        32'hA5A5A5A5};

    for (int a = 0; a < 16; a++) begin
      logic [31:0] v;
      v = $urandom;
      ram_mem[a] = v;
      ref_mem[a] = v;
    end

    do_reset();

    // Table of single transactions.
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].do_pre) begin
        ram_mem[vecs[k].addr] = vecs[k].preload;
        ref_mem[vecs[k].addr] = vecs[k].preload;
      end
      run_req(vecs[k].use_i, vecs[k].addr, vecs[k].dmode, vecs[k].addr, vecs[k].wdata,
              vecs[k].busy, vecs[k].busy, io, dv);
      if (vecs[k].dmode == 1)      check("tbl_dload", dv, vecs[k].exp_load);
      else if (vecs[k].dmode >= 2) check("tbl_store", ram_rd(vecs[k].addr), vecs[k].exp_load);
      else                         check("tbl_iload", io, vecs[k].exp_load);
    end

    // Simultaneous instruction and data request: data must go first.
    run_req(1'b1, 32'h40, 1, 32'h100, 32'h0, 1, 1, io, dv);
    check("simul_dload", dv, 32'hCAFEF00D);
    check("simul_iload", io, 32'hDEADBEEF);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run_req(mode != 1, 32'($urandom_range(0, 15)),
              (mode == 0) ? 0 : int'($urandom_range(1, 3)),
              32'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), io, dv);
    end
    check_counters("random");
    check("random_memerr", memerr, 0);

    // Statistics: 3 instruction + 2 data accesses, 1 BUSY cycle each.
    do_reset();
    for (int n = 0; n < 3; n++) run_req(1'b1, 32'(n), 0, 32'h0, 32'h0, 1, 1, io, dv);
    for (int n = 0; n < 2; n++) run_req(1'b0, 32'h0, 1, 32'(n + 4), 32'h0, 1, 1, io, dv);
    check_counters("stats");

    // RAM ERROR during an instruction access.
    do_reset();
    $display("txn %0d: ERROR during IACC", ++txn_no);
    iREN = 1; iaddr = 32'h44;
    @(posedge CLK); #1;
    ramstate = ERR; #1;
    check("err_ramREN", ramREN, 1);
    check("err_nohit", {ihit, dhit}, 0);
    @(posedge CLK); #1;
    ramstate = FREE; #1;
    check("err_memerr", memerr, 1);
    check("err_idle", ramREN, 0);
    iREN = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("err_sticky", memerr, 1);
    nRST = 0; #1;
    check("err_rst_clear", memerr, 0);
    @(posedge CLK); #1; nRST = 1;

    // Wait-counter timeout: BUSY forever.
    do_reset();
    $display("txn %0d: BUSY timeout", ++txn_no);
    dREN = 1; daddr = 32'h5;
    @(posedge CLK); #1;
    ramstate = BUSY;
    repeat (254) @(posedge CLK);
    #1;
    check("to_still_waiting", ramREN, 1);
    check("to_memerr_early", memerr, 0);
    @(posedge CLK); #1;
    check("to_memerr", memerr, 1);
    check("to_idle", ramREN, 0);
    dREN = 0; ramstate = FREE;
    @(posedge CLK); #1;

    // Data write aborted mid-access, instruction request waiting.
    do_reset();
    $display("txn %0d: aborted write", ++txn_no);
    dWEN = 1; daddr = 32'h200; dstore = 32'h99;
    @(posedge CLK); #1;
    ramstate = BUSY; #1;
    check("ab_ramWEN", ramWEN, 1);
    @(posedge CLK); #1;
    dWEN = 0; iREN = 1; iaddr = 32'h7; ramstate = ACCESS; #1;
    check("ab_enables", {ramREN, ramWEN}, 0);
    check("ab_nohit", {ihit, dhit}, 0);
    @(posedge CLK); #1;
    ramstate = FREE; #1;
    check("ab_idle", ramREN, 0);
    @(posedge CLK); #1;
    check("ab_iacc_addr", ramaddr, 32'h7);
    check("ab_iacc_ren", ramREN, 1);
    ramstate = ACCESS; ramload = 32'h55; #1;
    check("ab_ihit", {ihit, dhit}, 2'b10);
    check("ab_iload", iload, 32'h55);
    check("ab_memerr", memerr, 0);
    @(posedge CLK); #1;
    iREN = 0; ramstate = FREE;
    @(posedge CLK); #1;

    // Reset pulsed in the middle of a data access.
    do_reset();
    $display("txn %0d: reset mid-DACC", ++txn_no);
    dREN = 1; daddr = 32'h100;
    @(posedge CLK); #1;
    ramstate = BUSY;
    @(posedge CLK); #1;
    ramstate = ACCESS; ramload = 32'h1234; nRST = 0; #1;
    check("mr_enables", {ramREN, ramWEN}, 0);
    check("mr_dhit", dhit, 0);
    check("mr_dload", dload, 0);
    check("mr_ramaddr", ramaddr, 0);
    exp_i = 0; exp_d = 0; exp_stall = 0;
    check_counters("mr");
    ramstate = FREE;
    @(posedge CLK); #1;
    nRST = 1;
    @(posedge CLK); #1;
    check("mr_first_edge", ramREN, 1);
    ramstate = ACCESS; #1;
    check("mr_dhit_after", dhit, 1);
    check("mr_dload_after", dload, 32'h1234);
    @(posedge CLK); #1;
    dREN = 0; ramstate = FREE;
    @(posedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port iREN  in  1  instruction read request, held until ihit.
REQ-004 SHALL have port iaddr  in  32  instruction word address.
REQ-005 SHALL have port iload  out  32  instruction read data, valid when ihit=1.
REQ-006 SHALL have port ihit  out  1  one-cycle instruction completion strobe.
REQ-007 SHALL have port dREN  in  1  data read request, held until dhit.
REQ-008 SHALL have port dWEN  in  1  data write request, held until dhit.
REQ-009 SHALL have port daddr  in  32  data word address.
REQ-010 SHALL have port dstore  in  32  data write value.
REQ-011 SHALL have port dload  out  32  data read value, valid when dhit=1.
REQ-012 SHALL have port dhit  out  1  one-cycle data completion strobe.
REQ-013 SHALL have ports ramREN/ramWEN  out  1 each  RAM read/write enables.
REQ-014 SHALL have ports ramaddr/ramstore  out  32 each  RAM address and write data.
REQ-015 SHALL have port ramload  in  32  RAM read data.
REQ-016 SHALL have port ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-017 SHALL have port memerr  out  1  sticky error flag.
REQ-018 SHALL have ports icount/dcount/stallcount  out  32 each  statistics counters (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, DACC, IACC, DONE.
REQ-020 In IDLE: (dREN|dWEN)=1 -> DACC; else iREN=1 -> IACC; else stay. Data SHALL win every simultaneous request.
REQ-021 In DACC: SHALL drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. dREN&dWEN SHALL be treated as a write.
REQ-022 In IACC: SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0.
REQ-023 In DACC/IACC with ramstate=ACCESS: SHALL assert the matching hit combinationally that same cycle, present ramload on dload/iload, and go to DONE.
REQ-024 DONE SHALL drive all RAM enables 0, assert no hit, and return to IDLE next cycle. This gives a one-cycle bubble that lets the requester drop its request.
REQ-025 ramstate FREE or BUSY in DACC/IACC SHALL hold the state with outputs stable.
REQ-026 ramstate=ERROR in DACC/IACC SHALL set memerr (sticky until reset), assert no hit, and go to IDLE.
REQ-027 A request deasserted mid-access (e.g. dREN&dWEN fall in DACC) SHALL abort to IDLE next cycle, with RAM enables 0 in that cycle and no hit.
REQ-028 SHALL include an 8-bit wait counter that clears on entering DACC/IACC and increments each non-ACCESS cycle there. At 255 it SHALL set memerr and go to IDLE.
REQ-029 ihit and dhit SHALL never be asserted in the same cycle.
REQ-030 Outside DACC/IACC, ramaddr and ramstore SHALL be 0 and iload/dload SHALL be 0.

Reset
REQ-031 nRST=0 SHALL asynchronously force IDLE, wait counter 0, memerr 0 and all counters 0. All outputs SHALL be 0, including mid-access.
REQ-032 After nRST rises, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-033 Macro MEM_ARB_STATS_EN, when defined, SHALL enable three 32-bit wrapping counters:
  - icount: increments per ihit.
  - dcount: increments per dhit.
  - stallcount: increments per cycle in DACC/IACC without ACCESS.
REQ-034 Without MEM_ARB_STATS_EN the counter ports SHALL remain and be driven constant 0, with no counter registers synthesized.

Verification
REQ-035 Reset, then iREN=1 with iaddr=0x40; ramstate BUSY 2 cycles, then ACCESS with ramload=0xDEADBEEF -> ihit=1 for 1 cycle with iload=0xDEADBEEF, then DONE, then IDLE.
REQ-036 iREN=1 and dREN=1 asserted in the same cycle with daddr=0x100 -> DACC first and dhit first, then DONE, then IACC and ihit; ihit and dhit are never both high.
REQ-037 dWEN=1 with daddr=0x200 and dstore=0x12345678 -> ramWEN=1, ramaddr=0x200, ramstore=0x12345678 until ACCESS, then dhit=1.
REQ-038 ramstate=ERROR during IACC -> memerr=1, no ihit, IDLE next cycle; memerr stays 1 until nRST. Separately, ramstate held BUSY 255 cycles -> memerr=1.
REQ-039 nRST pulsed low mid-DACC -> ramREN=ramWEN=0 and dhit=0 immediately, FSM in IDLE; with MEM_ARB_STATS_EN, icount/dcount/stallcount=0.
REQ-040 With MEM_ARB_STATS_EN, 3 instruction and 2 data accesses, each with 1 BUSY cycle -> icount=3, dcount=2, stallcount=5; without the macro all three read 0.
